// File: rtl/vga_ctrl.sv
// 640x480@60 VGA timing generator: issues pixel requests ahead of the display
// window by PIX_LAT clocks and registers the returned data together with syncs.
module vga_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_VALID  = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_VALID  = 480,
    parameter int V_FRONT  = 10,
    parameter int PIX_LAT  = 1,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        rgb_valid,
    output logic        frame_start
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] RQ_H_LO = 10'(HA - PIX_LAT);
    localparam logic [9:0] RQ_H_HI = 10'(HA + H_VALID - 1 - PIX_LAT);
    localparam logic [9:0] DA_H_LO = 10'(HA);
    localparam logic [9:0] DA_H_HI = 10'(HA + H_VALID - 1);
    localparam logic [9:0] V_LO    = 10'(VA);
    localparam logic [9:0] V_HI    = 10'(VA + V_VALID - 1);
    localparam logic [9:0] HS_END  = 10'(H_SYNC);
    localparam logic [9:0] VS_END  = 10'(V_SYNC);

    logic [9:0]  cnt_h_q, cnt_h_d;
    logic [9:0]  cnt_v_q, cnt_v_d;
    logic [15:0] rgb_q, rgb_d;
    logic        rgb_valid_q, rgb_valid_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic        v_act, req_win, disp_win;

    always_comb begin
        cnt_h_d = cnt_h_q + 10'd1;
        cnt_v_d = cnt_v_q;
        if (cnt_h_q == H_LAST) begin
            cnt_h_d = '0;
            cnt_v_d = (cnt_v_q == V_LAST) ? '0 : cnt_v_q + 10'd1;
        end
    end

    // Request window leads the display window by PIX_LAT so returned data lands on time.
    assign v_act    = (cnt_v_q >= V_LO) && (cnt_v_q <= V_HI);
    assign req_win  = v_act && (cnt_h_q >= RQ_H_LO) && (cnt_h_q <= RQ_H_HI);
    assign disp_win = v_act && (cnt_h_q >= DA_H_LO) && (cnt_h_q <= DA_H_HI);

    assign pix_x = req_win ? (cnt_h_q - RQ_H_LO) : 10'h3FF;
    assign pix_y = req_win ? (cnt_v_q - V_LO)    : 10'h3FF;

    // Mux rather than AND-mask so an X on pix_data during blanking never reaches rgb.
    always_comb begin
        rgb_d         = disp_win ? pix_data : 16'h0000;
        rgb_valid_d   = disp_win;
        hsync_d       = (cnt_h_q < HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (cnt_v_q < VS_END) ? SYNC_POL : ~SYNC_POL;
        frame_start_d = (cnt_h_q == 10'd0) && (cnt_v_q == 10'd0);
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q       <= '0;
            cnt_v_q       <= '0;
            rgb_q         <= '0;
            rgb_valid_q   <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            cnt_h_q       <= cnt_h_d;
            cnt_v_q       <= cnt_v_d;
            rgb_q         <= rgb_d;
            rgb_valid_q   <= rgb_valid_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign rgb         = rgb_q;
    assign rgb_valid   = rgb_valid_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
- VGA timing generator and pixel-request master for the 640x480@60 display path.
- Runs on vga_clk (25 MHz) and drives pix_x/pix_y to the pixel generator, which answers with pix_data PIX_LAT cycles later.
- Pairs returned pixel data with hsync/vsync and emits aligned RGB565 to the DAC/HDMI encoder, plus a frame_start strobe.

Parameters:
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch
- H_VALID, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch
- V_VALID, 480, active lines
- V_FRONT, 10, vertical front porch
- PIX_LAT, 1, pixel-generator read latency in clocks, legal range 0..H_SYNC+H_BACK
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- vga_clk  in  1  pixel clock, 25 MHz
- sys_rst_n  in  1  reset, active-low
- pix_data  in  16  RGB565 returned by the pixel generator
- pix_x  out  10  requested X coordinate; 10'h3FF outside the request window
- pix_y  out  10  requested Y coordinate; 10'h3FF outside the request window
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- rgb  out  16  RGB565 to display; 0 outside the active area
- rgb_valid  out  1  high while rgb carries an active pixel
- frame_start  out  1  one-cycle pulse at frame origin

Behaviour:
- Interface: one clock, vga_clk. Reset sys_rst_n is asynchronous and active-low.
- Derived constants:
  - H_TOTAL = H_SYNC+H_BACK+H_VALID+H_FRONT (800)
  - V_TOTAL = V_SYNC+V_BACK+V_VALID+V_FRONT (525)
  - HA = H_SYNC+H_BACK (144)
  - VA = V_SYNC+V_BACK (35)
- Counters: cnt_h and cnt_v are 10 bits and reset to 0.
  - cnt_h increments every clock and wraps H_TOTAL-1 -> 0.
  - cnt_v increments when cnt_h wraps, and wraps V_TOTAL-1 -> 0 on the same edge that cnt_h wraps.
- Request window (combinational from the counters):
  - Condition: cnt_h in [HA-PIX_LAT, HA+H_VALID-1-PIX_LAT] and cnt_v in [VA, VA+V_VALID-1].
  - Inside the window: pix_x = cnt_h-(HA-PIX_LAT) and pix_y = cnt_v-VA.
  - Outside the window: both are 10'h3FF.
  - Coordinate (0,0) appears for exactly one clock per frame; the pixel generator uses it as a frame tick, so (0,0) must never appear in blanking.
- Display window: cnt_h in [HA, HA+H_VALID-1] and cnt_v in [VA, VA+V_VALID-1]. The pix_data present while in this window answers the request issued PIX_LAT clocks earlier.
- Output register stage: all of the following update on the same edge, so every output is 1 clock behind the counter state.
  - rgb <= display window ? pix_data : 0
  - rgb_valid <= display window
  - hsync <= (cnt_h < H_SYNC) ? SYNC_POL : ~SYNC_POL
  - vsync <= (cnt_v < V_SYNC) ? SYNC_POL : ~SYNC_POL
  - frame_start <= (cnt_h==0 && cnt_v==0)
- Reset values: rgb=0, rgb_valid=0, frame_start=0, hsync=vsync=~SYNC_POL (deasserted). pix_x/pix_y read 10'h3FF (counters are 0, outside the window).
- Reset mid-frame: counters and outputs return to their reset values immediately. The timing restarts from frame origin on the first edge after release; no partial line is completed.
- pix_data is sampled only inside the display window. X/Z on pix_data in blanking must not reach rgb.
- PIX_LAT=0: request window equals display window, and pix_data is treated as combinational.
- Arithmetic is unsigned 10-bit. Subtractions are evaluated only inside their window, so no underflow reaches the ports.

Test Plan:
1. Reset then free-run 2 frames -> first frame_start pulse 1 clock after release. frame_start period = 420000 clocks. hsync low 96 of every 800 clocks. vsync low 1600 of every 420000 clocks.
2. PIX_LAT=1, line VA -> pix_x=0/pix_y=0 at cnt_h=143 and pix_x=639 at cnt_h=782. pix_x=10'h3FF at cnt_h=142 and cnt_h=783. (0,0) occurs exactly once per frame.
3. Pixel-generator model returning {pix_y[5:0],pix_x[9:0]} with latency PIX_LAT -> every rgb_valid cycle has rgb equal to the model value for that position. Exactly 640 rgb_valid cycles per active line, 480 active lines per frame. Repeat with PIX_LAT=0 and PIX_LAT=2.
4. pix_data driven 16'hFFFF in blanking -> rgb=0 whenever rgb_valid=0.
5. Assert sys_rst_n low at cnt_h=400, cnt_v=200 for 3 clocks -> outputs take reset values asynchronously. After release, timing resumes from (0,0) with frame_start 1 clock later.
6. SYNC_POL=1 -> hsync/vsync idle 0 and pulse high, with widths unchanged from scenario 1.
